// File: rtl/funnel_pkg.sv
// Shared funnel mode decode, used by both the funnel and the defunnel so that
// both ends agree on the chunk count for every config byte.
package funnel_pkg;

  localparam int unsigned CHUNK_W_DEF = 32;
  localparam int unsigned CHUNKS_DEF  = 8;

  // Raw R field: i_cfg[$clog2(chunks):0]; chunks is a power of two, so a mask does it.
  function automatic int unsigned r_field(input logic [7:0] cfg, input int unsigned chunks);
    int unsigned mask;
    mask = (chunks << 1) - 1;
    return {24'd0, cfg} & mask;
  endfunction

  function automatic logic r_legal(input logic [7:0] cfg, input int unsigned chunks);
    int unsigned r;
    r = r_field(cfg, chunks);
    return (r != 0) && ((r & (r - 1)) == 0) && (r <= chunks);
  endfunction

  function automatic int unsigned r_decode(input logic [7:0] cfg, input int unsigned chunks);
    return r_legal(cfg, chunks) ? r_field(cfg, chunks) : chunks;
  endfunction

endpackage

// File: rtl/funnel_dat_sel.sv
// Chunk mux: picks chunk i_idx out of the held wide word.
module funnel_dat_sel #(
  parameter int unsigned CHUNK_W = 32,
  parameter int unsigned CHUNKS  = 8
) (
  input  logic [CHUNKS*CHUNK_W-1:0]  i_hold,
  input  logic [$clog2(CHUNKS)-1:0]  i_idx,
  output logic [CHUNK_W-1:0]         o_chunk
);

  always_comb begin
    o_chunk = i_hold[i_idx*CHUNK_W +: CHUNK_W];
  end

endmodule

// File: rtl/funnel_dat.sv
// Wide-to-narrow serializer: emits the lowest R chunks of each accepted word.
// Optional statistics outputs are enabled with FUNNEL_DAT_STATS_EN.
module funnel_dat
  import funnel_pkg::*;
#(
  parameter int unsigned CHUNK_W = CHUNK_W_DEF,
  parameter int unsigned CHUNKS  = CHUNKS_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHUNKS*CHUNK_W-1:0] i_dat,
  input  logic [7:0]                i_cfg,
  input  logic                      i_valid,
  output logic                      i_ready,
  output logic [CHUNK_W-1:0]        o_dat,
  output logic [7:0]                o_mode,
  output logic                      o_last,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic                      o_err
`ifdef FUNNEL_DAT_STATS_EN
  ,
  output logic [CNT_W-1:0]          o_words,
  output logic [CNT_W-1:0]          o_beats,
  output logic                      o_err_sticky
`endif
);

  localparam int unsigned IW = $clog2(CHUNKS);
  localparam int unsigned BW = IW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [BW-1:0]             beat_q, beat_d;
  logic [BW-1:0]             r_q, r_d;
  logic [CHUNKS*CHUNK_W-1:0] hold_q, hold_d;
  logic [7:0]                mode_q, mode_d;
  logic                      err_q, err_d;

  logic send, last, xfer, accept;

  assign send    = (state_q == SEND);
  assign last    = send && (beat_q == r_q - 1'b1);
  assign xfer    = send && o_ready;
  assign i_ready = !send || (xfer && last);
  assign accept  = i_valid && i_ready;

  // Acceptance takes priority: on a last-beat transfer it reloads in the same cycle.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    r_d     = r_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    if (accept) begin
      state_d = SEND;
      beat_d  = '0;
      r_d     = BW'(r_decode(i_cfg, CHUNKS));
      hold_d  = i_dat;
      mode_d  = i_cfg;
      err_d   = !r_legal(i_cfg, CHUNKS);
    end else if (xfer) begin
      if (last) state_d = IDLE;
      else      beat_d  = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      r_q     <= '0;
      hold_q  <= '0;
      mode_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      r_q     <= r_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  funnel_dat_sel #(
    .CHUNK_W (CHUNK_W),
    .CHUNKS  (CHUNKS)
  ) u_sel (
    .i_hold  (hold_q),
    .i_idx   (beat_q[IW-1:0]),
    .o_chunk (o_dat)
  );

  assign o_valid = send;
  assign o_last  = last;
  assign o_mode  = mode_q;
  assign o_err   = err_q;

`ifdef FUNNEL_DAT_STATS_EN
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             sticky_q, sticky_d;

  always_comb begin
    words_d  = words_q;
    beats_d  = beats_q;
    sticky_d = sticky_q | err_q;
    if (accept && (words_q != '1)) words_d = words_q + 1'b1;
    if (xfer && (beats_q != '1))   beats_d = beats_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      words_q  <= '0;
      beats_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      words_q  <= words_d;
      beats_q  <= beats_d;
      sticky_q <= sticky_d;
    end
  end

  assign o_words      = words_q;
  assign o_beats      = beats_q;
  assign o_err_sticky = sticky_q;
`else
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_funnel_dat.sv
// Self-checking bench for funnel_dat against a queue-based beat model.
module tb_funnel_dat;

  localparam int unsigned CW = 32;
  localparam int unsigned NC = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC*CW-1:0]  i_dat;
  logic [7:0]        i_cfg;
  logic              i_valid;
  logic              i_ready;
  logic [CW-1:0]     o_dat;
  logic [7:0]        o_mode;
  logic              o_last;
  logic              o_valid;
  logic              o_ready;
  logic              o_err;

  always #5 clk = ~clk;

  funnel_dat #(
    .CHUNK_W (CW),
    .CHUNKS  (NC),
    .CNT_W   (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_dat   (i_dat),
    .i_cfg   (i_cfg),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o_dat   (o_dat),
    .o_mode  (o_mode),
    .o_last  (o_last),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_err   (o_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of chunks still to be sent for the current word.
  logic [CW-1:0] mq[$];
  logic [7:0]    m_mode = 8'h00;
  bit            m_err  = 1'b0;
  bit            m_acc  = 1'b0;

  logic [CW-1:0] seen[$];
  int            seen_cyc[$];
  int            err_seen;

  function automatic bit model_legal(input logic [7:0] cfg);
    int unsigned r;
    r = cfg % 16;
    return (r != 0) && ((r & (r - 1)) == 0) && (r <= NC);
  endfunction

  function automatic int unsigned model_beats(input logic [7:0] cfg);
    return model_legal(cfg) ? (cfg % 16) : NC;
  endfunction

  function automatic bit model_ready();
    return (mq.size() == 0) || (o_ready && mq.size() == 1);
  endfunction

  function automatic logic [43:0] exp_vec();
    if (mq.size() != 0)
      return {model_ready(), 1'b1, mq.size() == 1, m_err, m_mode, mq[0]};
    return {model_ready(), 1'b0, 1'b0, m_err, 8'h00, 32'h0};
  endfunction

  function automatic logic [43:0] obs_vec();
    if (mq.size() != 0)
      return {i_ready, o_valid, o_last, o_err, o_mode, o_dat};
    return {i_ready, o_valid, o_last, o_err, 8'h00, 32'h0};
  endfunction

  task automatic advance();
    bit acc;
    bit pop;
    acc = i_valid && !reset && model_ready();
    pop = o_ready && (mq.size() > 0);
    @(posedge clk);
    m_acc = 1'b0;
    if (reset) begin
      mq.delete();
      m_err  = 1'b0;
      m_mode = 8'h00;
    end else begin
      if (pop) void'(mq.pop_front());
      m_err = acc && !model_legal(i_cfg);
      if (acc) begin
        m_acc  = 1'b1;
        m_mode = i_cfg;
        for (int unsigned k = 0; k < model_beats(i_cfg); k++) mq.push_back(i_dat[k*CW +: CW]);
      end
    end
    @(negedge clk);
  endtask

  task automatic note_beat(input int c);
    if (o_valid && o_ready) begin
      seen.push_back(o_dat);
      seen_cyc.push_back(c);
    end
    if (o_err) err_seen++;
  endtask

  task automatic fill_word(input logic [CW-1:0] base);
    for (int unsigned k = 0; k < NC; k++) i_dat[k*CW +: CW] = base + CW'(k);
  endtask

  task automatic test_reset();
    reset = 1'b1; i_valid = 1'b0; o_ready = 1'b1; i_cfg = 8'h00; i_dat = '0;
    advance();
    advance();
    #1;
    checks++;
    if ({o_valid, o_last, o_err, i_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_ctrl: got v/l/e/r=%b required 0001", {o_valid, o_last, o_err, i_ready});
    end
    checks++;
    if ({o_mode, o_dat} !== 40'h0) begin
      errors++;
      $display("FAIL reset_data: got mode=%h dat=%h required 0/0", o_mode, o_dat);
    end
    reset = 1'b0;
    advance();
  endtask

  task automatic test_r4();
    seen.delete(); seen_cyc.delete();
    fill_word(32'h0); i_cfg = 8'd4; o_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      i_valid = (c == 0);
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL r4 c%0d: got %h required %h", c, obs_vec(), exp_vec());
      end
      note_beat(c);
      advance();
    end
    checks++;
    if (seen.size() != 4 || seen[0] !== 0 || seen[1] !== 1 || seen[2] !== 2 || seen[3] !== 3 ||
        seen_cyc[0] != 1 || seen_cyc[3] != 4) begin
      errors++;
      $display("FAIL r4_seq: got %0d beats required 4 beats 0..3 in cycles 1..4", seen.size());
    end
  endtask

  task automatic test_back_to_back();
    int wi;
    seen.delete(); seen_cyc.delete();
    wi = 0; i_cfg = 8'd2; o_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      fill_word(wi == 0 ? 32'hA0 : 32'hB0);
      i_valid = (wi < 2);
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b c%0d: got %h required %h", c, obs_vec(), exp_vec());
      end
      note_beat(c);
      advance();
      if (m_acc) wi++;
    end
    checks++;
    if (seen.size() != 4 || seen[0] !== 32'hA0 || seen[1] !== 32'hA1 || seen[2] !== 32'hB0 ||
        seen[3] !== 32'hB1 || seen_cyc[3] - seen_cyc[0] != 3) begin
      errors++;
      $display("FAIL b2b_seq: got %0d beats required A0 A1 B0 B1 gap-free", seen.size());
    end
  endtask

  task automatic test_stall();
    seen.delete(); seen_cyc.delete();
    for (int unsigned k = 0; k < NC; k++) i_dat[k*CW +: CW] = $urandom;
    i_cfg = 8'd8;
    for (int c = 0; c < 30; c++) begin
      i_valid = (c == 0);
      o_ready = (c % 3 == 1);
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stall c%0d: got %h required %h", c, obs_vec(), exp_vec());
      end
      note_beat(c);
      advance();
    end
    checks++;
    if (seen.size() != 8) begin
      errors++;
      $display("FAIL stall_cnt: got %0d beats required 8", seen.size());
    end
    o_ready = 1'b1;
  endtask

  task automatic test_r1();
    int wi;
    seen.delete(); seen_cyc.delete();
    wi = 0; i_cfg = 8'd1; o_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      fill_word(32'h100 * (wi + 1));
      i_valid = (wi < 5);
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL r1 c%0d: got %h required %h", c, obs_vec(), exp_vec());
      end
      note_beat(c);
      advance();
      if (m_acc) wi++;
    end
    checks++;
    if (seen.size() != 5 || seen_cyc[4] - seen_cyc[0] != 4 || seen[4] !== 32'h500) begin
      errors++;
      $display("FAIL r1_seq: got %0d beats required 5 in 5 cycles", seen.size());
    end
  endtask

  task automatic test_illegal();
    logic [7:0] cfgs [4];
    cfgs[0] = 8'd3; cfgs[1] = 8'd0; cfgs[2] = 8'h29; cfgs[3] = 8'hF4;
    o_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      seen.delete(); seen_cyc.delete(); err_seen = 0;
      fill_word(32'h40 * t); i_cfg = cfgs[t];
      for (int c = 0; c < 11; c++) begin
        i_valid = (c == 0);
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL illegal cfg=%h c%0d: got %h required %h", cfgs[t], c, obs_vec(), exp_vec());
        end
        note_beat(c);
        advance();
      end
      checks++;
      if (seen.size() != int'(model_beats(cfgs[t])) || err_seen != (model_legal(cfgs[t]) ? 0 : 1)) begin
        errors++;
        $display("FAIL illegal_sum cfg=%h: got beats=%0d err=%0d required beats=%0d err=%0d",
                 cfgs[t], seen.size(), err_seen, model_beats(cfgs[t]), model_legal(cfgs[t]) ? 0 : 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    seen.delete(); seen_cyc.delete();
    fill_word(32'h700); i_cfg = 8'd8; o_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i_valid = (c == 0);
      #1;
      note_beat(c);
      advance();
    end
    reset = 1'b1;
    advance();
    reset = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b ready=%b required 0/1", o_valid, i_ready);
    end
    seen.delete(); seen_cyc.delete();
    fill_word(32'hC00);
    for (int c = 0; c < 10; c++) begin
      i_valid = (c == 0);
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid_next c%0d: got %h required %h", c, obs_vec(), exp_vec());
      end
      note_beat(c);
      advance();
    end
    checks++;
    if (seen.size() != 8 || seen[0] !== 32'hC00) begin
      errors++;
      $display("FAIL reset_mid_first: got %0d beats required 8 starting at c00", seen.size());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      reset   = ($urandom_range(0, 99) == 0);
      i_valid = ($urandom_range(0, 9) < 7);
      o_ready = ($urandom_range(0, 9) < 7);
      i_cfg   = $urandom;
      for (int unsigned k = 0; k < NC; k++) i_dat[k*CW +: CW] = $urandom;
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random c%0d: got %h required %h", c, obs_vec(), exp_vec());
      end
      advance();
    end
    reset = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_r4();
    test_back_to_back();
    test_stall();
    test_r1();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
